// File: rtl/esp_boot_pkg.sv
// Shared state encoding, default 12 MHz cycle counts and a small constant helper
// for the ESP8266 boot sequencer.
package esp_boot_pkg;

    typedef enum logic [1:0] {
        RST_ASSERT = 2'b00,
        BOOT_WAIT  = 2'b01,
        RUN        = 2'b10
    } boot_state_e;

    localparam int unsigned DEF_RST_LOW_CYCLES   = 1200;
    localparam int unsigned DEF_BOOT_WAIT_CYCLES = 1200000;
    localparam int unsigned DEF_BREAK_CYCLES     = 240000;
    localparam int unsigned DEF_ACT_CYCLES       = 600000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/esp_boot_seq_act_stretch.sv
// Activity stretcher: led is high while line is low and for CYCLES cycles after
// the last low sample; cleared and idle whenever en is low.
module act_stretch
    import esp_boot_pkg::*;
#(
    parameter int unsigned CYCLES = DEF_ACT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic line,
    output logic led
);

    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          led_q, led_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        cnt_d = cnt_q;
        led_d = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (!line) begin
            cnt_d = CW'(CYCLES);
            led_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            led_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            led_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/esp_boot_seq.sv
// ESP8266 reset/boot sequencer with a gated UART bridge and activity LEDs.
// Optional: define ESP_BREAK_RESET_EN to re-run the reset on a long host break.
module esp_boot_seq
    import esp_boot_pkg::*;
#(
    parameter int unsigned RST_LOW_CYCLES   = DEF_RST_LOW_CYCLES,
    parameter int unsigned BOOT_WAIT_CYCLES = DEF_BOOT_WAIT_CYCLES,
    parameter int unsigned BREAK_CYCLES     = DEF_BREAK_CYCLES,
    parameter int unsigned ACT_CYCLES       = DEF_ACT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_reset,
    input  logic       host_txd,
    input  logic       esp_txd_in,
    output logic       esp_rxd_out,
    output logic       host_rxd_out,
    output logic       esp_reset_n,
    output logic       esp_gpio2,
    output logic       bridge_en,
    output logic       led_tx,
    output logic       led_rx,
    output logic [1:0] state_o
);

    localparam logic [1:0] ST_RST  = RST_ASSERT;
    localparam logic [1:0] ST_BOOT = BOOT_WAIT;
    localparam logic [1:0] ST_RUN  = RUN;

    localparam int unsigned CNT_W = $clog2(max_u(RST_LOW_CYCLES, BOOT_WAIT_CYCLES) + 1);

    if (RST_LOW_CYCLES == 0 || BOOT_WAIT_CYCLES == 0 || BREAK_CYCLES == 0 || ACT_CYCLES == 0)
    begin : g_param_check
        $error("esp_boot_seq: cycle parameters must be non-zero");
    end

    logic             host_meta_q, host_sync_q;
    logic             esp_meta_q, esp_sync_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             esp_reset_n_q, esp_reset_n_d;
    logic             bridge_en_q, bridge_en_d;
    logic             esp_rxd_q, esp_rxd_d;
    logic             host_rxd_q, host_rxd_d;
    logic             break_hit;

`ifdef ESP_BREAK_RESET_EN
    localparam int unsigned BRK_W = $clog2(BREAK_CYCLES + 1);

    logic [BRK_W-1:0] brk_cnt_q, brk_cnt_d;
    logic             break_armed_q, break_armed_d;

    assign break_hit = (state_q == ST_RUN) && break_armed_q && !host_sync_q &&
                       (brk_cnt_q == BRK_W'(BREAK_CYCLES - 1));

    // Arming needs a high sample in RUN, so a line still low after a reset cannot retrigger.
    always_comb begin
        brk_cnt_d     = '0;
        break_armed_d = 1'b0;
        if (state_q == ST_RUN && state_d == ST_RUN) begin
            if (host_sync_q) begin
                break_armed_d = 1'b1;
            end else if (break_armed_q) begin
                break_armed_d = 1'b1;
                brk_cnt_d     = brk_cnt_q + BRK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            brk_cnt_q     <= '0;
            break_armed_q <= 1'b0;
        end else begin
            brk_cnt_q     <= brk_cnt_d;
            break_armed_q <= break_armed_d;
        end
    end
`else
    assign break_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            ST_RST: begin
                if (cnt_q == CNT_W'(RST_LOW_CYCLES - 1)) begin
                    state_d = ST_BOOT;
                    cnt_d   = '0;
                end
            end
            ST_BOOT: begin
                if (cnt_q == CNT_W'(BOOT_WAIT_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = '0;
            end
        endcase

        if (req_reset || break_hit) begin
            state_d = ST_RST;
            cnt_d   = '0;
        end

        // Outputs follow the next state so they change on the same edge as state_o.
        esp_reset_n_d = (state_d != ST_RST);
        bridge_en_d   = (state_d == ST_RUN);
        esp_rxd_d     = bridge_en_d ? host_sync_q : 1'b1;
        host_rxd_d    = bridge_en_d ? esp_sync_q  : 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            host_meta_q   <= 1'b1;
            host_sync_q   <= 1'b1;
            esp_meta_q    <= 1'b1;
            esp_sync_q    <= 1'b1;
            state_q       <= ST_RST;
            cnt_q         <= '0;
            esp_reset_n_q <= 1'b0;
            bridge_en_q   <= 1'b0;
            esp_rxd_q     <= 1'b1;
            host_rxd_q    <= 1'b1;
        end else begin
            host_meta_q   <= host_txd;
            host_sync_q   <= host_meta_q;
            esp_meta_q    <= esp_txd_in;
            esp_sync_q    <= esp_meta_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            esp_reset_n_q <= esp_reset_n_d;
            bridge_en_q   <= bridge_en_d;
            esp_rxd_q     <= esp_rxd_d;
            host_rxd_q    <= host_rxd_d;
        end
    end

    act_stretch #(.CYCLES(ACT_CYCLES)) u_led_tx (
        .clk  (clk),
        .rst  (rst),
        .en   (bridge_en_d),
        .line (host_sync_q),
        .led  (led_tx)
    );

    act_stretch #(.CYCLES(ACT_CYCLES)) u_led_rx (
        .clk  (clk),
        .rst  (rst),
        .en   (bridge_en_d),
        .line (esp_sync_q),
        .led  (led_rx)
    );

    assign esp_rxd_out  = esp_rxd_q;
    assign host_rxd_out = host_rxd_q;
    assign esp_reset_n  = esp_reset_n_q;
    assign esp_gpio2    = 1'b1;
    assign bridge_en    = bridge_en_q;
    assign state_o      = state_q;

endmodule
